line_buffer_sync: RTL and testbench

Single-clock, parametrised line buffer for the pixel stream (colour + start-of-frame bit), used where source and sink share a clock domain.
- Generalises depth and almost-full cushion.
- Adds occupancy reporting, sticky overflow detection, and automatic frame resynchronisation: after an overflow it drops pixels up to the next start-of-frame.
- Sits between the frame-source/processing chain and the video sink.

---
 rtl/line_buffer_sync.sv | 198 +++++++++++++++++++
 tb/tb_line_buffer_sync.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_sync.sv
// -----------------------------------------------------------------------------
// line_buffer_sync
//
// Single-clock first-word-fall-through line buffer for the pixel stream.
// Each stream word is CD+1 bits: bit CD flags start-of-frame and bits CD-1:0
// carry the colour. The buffer reports its occupancy and latches a sticky
// overflow flag. After a pixel is lost it resynchronises to the frame
// structure: it drops incoming pixels until the next start-of-frame pixel
// can be stored.
//
// Parameters:
//   CD        colour depth (stream word is CD+1 bits)
//   DEPTH     number of entries (power of two, >= 8)
//   AF_MARGIN almost-full cushion (1 <= AF_MARGIN < DEPTH)
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   si_data   input pixel {start, colour}
//   si_valid  input pixel present (a valid pixel that is not stored is lost)
//   si_ready  advisory back-pressure, low when almost full
//   so_data   head-of-buffer pixel (don't-care while so_valid is low)
//   so_valid  head pixel valid (buffer not empty)
//   so_ready  sink consumes the head pixel this cycle
//   level     current occupancy, 0..DEPTH
//   ovf       sticky overflow flag
//   ovf_clr   one-cycle pulse that clears ovf (and the statistics counters)
//   resync    high while pixels are being dropped up to the next start
//
// Optional feature, enabled by defining LINE_BUFFER_STATS_EN:
//   drop_cnt  saturating count of discarded pixels
//   frame_cnt wrapping count of accepted start-of-frame pixels
// -----------------------------------------------------------------------------
module line_buffer_sync #(
  parameter int CD        = 12,
  parameter int DEPTH     = 1024,
  parameter int AF_MARGIN = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CD:0]                si_data,
  input  logic                       si_valid,
  output logic                       si_ready,
  output logic [CD:0]                so_data,
  output logic                       so_valid,
  input  logic                       so_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic                       resync
`ifdef LINE_BUFFER_STATS_EN
  ,
  output logic [15:0]                drop_cnt,
  output logic [15:0]                frame_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic {PASS = 1'b0, DROP = 1'b1} state_t;

  state_t          state_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic            ovf_reg;

  // Storage array with a registered read port.
  logic [CD:0]     mem [DEPTH];
  logic [CD:0]     mem_q_reg;
  logic            bypass_reg;
  logic [CD:0]     bypass_data_reg;

  logic            full;
  logic            empty;
  logic            almost_full;
  logic            pop;
  logic            can_write;
  logic            is_start;
  logic            wr_en;
  logic            lost;
  logic [AW-1:0]   rd_addr_next;

  assign full        = (level_reg == LW'(DEPTH));
  assign empty       = (level_reg == '0);
  assign almost_full = (level_reg >= LW'(DEPTH - AF_MARGIN));

  assign pop       = !empty && so_ready;
  // A full buffer still has room when the head leaves on the same edge.
  assign can_write = !full || pop;
  assign is_start  = si_data[CD];

  always_comb begin
    wr_en = 1'b0;
    if (si_valid) begin
      if (state_reg == PASS) begin
        wr_en = can_write;
      end else begin
        wr_en = is_start && can_write;
      end
    end
  end

  // Every valid pixel that is not stored is lost, whether it overflowed a
  // full buffer or was discarded while waiting for the next frame start.
  assign lost = si_valid && !wr_en;

  assign rd_addr_next = pop ? (rd_ptr_reg + AW'(1)) : rd_ptr_reg;

  // Control path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= PASS;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_addr_next;

      case ({wr_en, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase

      // Setting takes priority over a coincident clear.
      if (lost) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end

      case (state_reg)
        PASS: if (lost) state_reg <= DROP;
        DROP: if (wr_en) state_reg <= PASS;
        default: state_reg <= PASS;
      endcase
    end
  end

  // Data path. The read address looks one pop ahead so that the registered
  // read already holds the next head word. The only case the array cannot
  // supply is a write landing on that very address in the same edge (the
  // buffer was empty, or is about to become empty); that word is forwarded
  // from a side register instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= si_data;
    end
    mem_q_reg       <= mem[rd_addr_next];
    bypass_reg      <= wr_en && (wr_ptr_reg == rd_addr_next);
    bypass_data_reg <= si_data;
  end

  assign so_data  = bypass_reg ? bypass_data_reg : mem_q_reg;
  assign so_valid = !empty;
  assign si_ready = !almost_full;
  assign level    = level_reg;
  assign ovf      = ovf_reg;
  assign resync   = (state_reg == DROP);

`ifdef LINE_BUFFER_STATS_EN
  logic [15:0] drop_cnt_reg;
  logic [15:0] frame_cnt_reg;
  logic        frame_inc;

  assign frame_inc = wr_en && is_start;

  // An increment coinciding with a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
    end else begin
      if (ovf_clr) begin
        drop_cnt_reg <= lost ? 16'd1 : 16'd0;
      end else if (lost && (drop_cnt_reg != 16'hFFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end

      if (ovf_clr) begin
        frame_cnt_reg <= frame_inc ? 16'd1 : 16'd0;
      end else if (frame_inc) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign drop_cnt  = drop_cnt_reg;
  assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_line_buffer_sync.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_sync
//
// Directed bench for line_buffer_sync with CD=12, DEPTH=8, AF_MARGIN=2.
// Inputs change 1 ns after a rising edge; outputs are checked at that same
// point, so every check sees the state left by the preceding edge.
// -----------------------------------------------------------------------------
module tb_line_buffer_sync;

  localparam int CD        = 12;
  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 2;
  localparam int LW        = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [CD:0]   si_data;
  logic          si_valid;
  logic          si_ready;
  logic [CD:0]   so_data;
  logic          so_valid;
  logic          so_ready;
  logic [LW-1:0] level;
  logic          ovf;
  logic          ovf_clr;
  logic          resync;
`ifdef LINE_BUFFER_STATS_EN
  logic [15:0]   drop_cnt;
  logic [15:0]   frame_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  line_buffer_sync #(
    .CD(CD),
    .DEPTH(DEPTH),
    .AF_MARGIN(AF_MARGIN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .si_data(si_data),
    .si_valid(si_valid),
    .si_ready(si_ready),
    .so_data(so_data),
    .so_valid(so_valid),
    .so_ready(so_ready),
    .level(level),
    .ovf(ovf),
    .ovf_clr(ovf_clr),
    .resync(resync)
`ifdef LINE_BUFFER_STATS_EN
    ,
    .drop_cnt(drop_cnt),
    .frame_cnt(frame_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    si_data  = '0;
    si_valid = 1'b0;
    so_ready = 1'b0;
    ovf_clr  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_so_valid", 32'(so_valid), 32'd0);
    chk("rst_si_ready", 32'(si_ready), 32'd1);
    chk("rst_ovf",      32'(ovf),      32'd0);
    chk("rst_resync",   32'(resync),   32'd0);

    // Fill to the almost-full threshold (8-2 = 6) without reading
    si_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      si_data = 13'(16'h010 + i);
      tick();
      $display("write %03h level=%0d si_ready=%0d", si_data, level, si_ready);
      if (i == 4) begin
        chk("af_level5",    32'(level),    32'd5);
        chk("af_si_ready5", 32'(si_ready), 32'd1);
      end
    end
    chk("af_level6",    32'(level),    32'd6);
    chk("af_si_ready6", 32'(si_ready), 32'd0);
    chk("af_ovf",       32'(ovf),      32'd0);
    chk("af_so_valid",  32'(so_valid), 32'd1);
    chk("af_head",      32'(so_data),  32'h010);

    // Fill to full, then write with a simultaneous pop
    si_data = 13'h016; tick();
    si_data = 13'h017; tick();
    chk("full_level", 32'(level), 32'd8);
    si_data  = 13'h018;
    so_ready = 1'b1;
    chk("fullpop_head_before", 32'(so_data), 32'h010);
    tick();
    $display("write 018 with pop level=%0d ovf=%0d", level, ovf);
    chk("fullpop_level", 32'(level),   32'd8);
    chk("fullpop_ovf",   32'(ovf),     32'd0);
    chk("fullpop_head",  32'(so_data), 32'h011);

    // Overflow: three non-start pixels into a full buffer with no pop
    so_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      si_data = 13'(16'h020 + i);
      tick();
      $display("lost %03h ovf=%0d resync=%0d level=%0d", si_data, ovf, resync, level);
      chk("ovf_set",    32'(ovf),    32'd1);
      chk("ovf_resync", 32'(resync), 32'd1);
      chk("ovf_level",  32'(level),  32'd8);
    end

    // Start pixel while draining ends the drop
    si_data  = 13'h1001;
    so_ready = 1'b1;
    chk("drain_0", 32'(so_data), 32'h011);
    tick();
    $display("start 1001 accepted resync=%0d level=%0d", resync, level);
    chk("sof_resync", 32'(resync), 32'd0);
    chk("sof_level",  32'(level),  32'd8);
    chk("sof_ovf",    32'(ovf),    32'd1);

    // Remaining originals 012..018, then the start pixel
    si_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("drain_seq", 32'(so_data), (i < 7) ? 32'(16'h012 + i) : 32'h1001);
      $display("read %04h", so_data);
      tick();
    end
    chk("drained_level",    32'(level),    32'd0);
    chk("drained_so_valid", 32'(so_valid), 32'd0);

    // Single start pixel into an empty buffer: visible one edge later
    so_ready = 1'b0;
    si_valid = 1'b1;
    si_data  = 13'h1ABC;
    tick();
    si_valid = 1'b0;
    $display("write 1abc so_valid=%0d so_data=%04h", so_valid, so_data);
    chk("lat_so_valid", 32'(so_valid), 32'd1);
    chk("lat_so_data",  32'(so_data),  32'h1ABC);
    chk("lat_level",    32'(level),    32'd1);
    so_ready = 1'b1;
    tick();
    chk("lat_pop_level", 32'(level),    32'd0);
    chk("lat_pop_valid", 32'(so_valid), 32'd0);
    so_ready = 1'b0;

    // ovf_clr with no new loss clears the flag
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    $display("ovf_clr ovf=%0d", ovf);
    chk("clr_ovf", 32'(ovf), 32'd0);

    // Refill, then ovf_clr coincident with a lost pixel: set wins
    si_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      si_data = 13'(16'h030 + i);
      tick();
    end
    chk("refill_level",  32'(level),  32'd8);
    chk("refill_resync", 32'(resync), 32'd0);
    si_data = 13'h040;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    $display("lost 040 with ovf_clr ovf=%0d", ovf);
    chk("clr_vs_set_ovf",    32'(ovf),    32'd1);
    chk("clr_vs_set_resync", 32'(resync), 32'd1);

    // In DROP a non-start pixel is discarded even with room
    si_data  = 13'h041;
    so_ready = 1'b1;
    tick();
    chk("drop_nonstart_level",  32'(level),   32'd7);
    chk("drop_nonstart_resync", 32'(resync),  32'd1);
    chk("drop_head",            32'(so_data), 32'h031);
    // A start pixel with room is stored without a pop
    si_data  = 13'h1002;
    so_ready = 1'b0;
    tick();
    chk("drop_sof_level",  32'(level),  32'd8);
    chk("drop_sof_resync", 32'(resync), 32'd0);

    // Pop three to reach level 5, then reset mid-stream
    si_valid = 1'b0;
    so_ready = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_level", 32'(level), 32'd5);
    si_valid = 1'b1;
    si_data  = 13'h050;
    reset    = 1'b1;
    tick();
    $display("mid reset level=%0d so_valid=%0d", level, so_valid);
    chk("mrst_level",    32'(level),    32'd0);
    chk("mrst_so_valid", 32'(so_valid), 32'd0);
    chk("mrst_si_ready", 32'(si_ready), 32'd1);
    chk("mrst_resync",   32'(resync),   32'd0);
    chk("mrst_ovf",      32'(ovf),      32'd0);
`ifdef LINE_BUFFER_STATS_EN
    chk("mrst_drop_cnt",  32'(drop_cnt),  32'd0);
    chk("mrst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif

    // Normal operation after reset
    reset    = 1'b0;
    so_ready = 1'b0;
    si_data  = 13'h1055;
    tick();
    si_valid = 1'b0;
    chk("post_rst_data",  32'(so_data), 32'h1055);
    chk("post_rst_level", 32'(level),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
